// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a FIFO read port and
// serialises each one as an 8N1/8N2 frame on TX_O.
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       EN_I,
    input  logic       EMPTY_I,
    input  logic [7:0] R_DATA_I,
    output logic       RE_O,
    output logic       TX_O,
    output logic       BUSY_O
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign RE_O    = (state_q == IDLE) & EN_I & ~EMPTY_I & RST_NI;
    assign TX_O    = tx_q;
    assign BUSY_O  = busy_q;

    // tx_d always reflects the bit of the state being entered,
    // so TX_O changes exactly on bit boundaries.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (RE_O) begin
                    shift_d = R_DATA_I;
                    baud_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Scoreboard bench: stimulus queues expected bytes, serial
// monitors decode TX frames and compare against the queue.
module tb_uart_tx_fifo_reader;

    logic       clk;
    logic       rst0_n, en0, empty0, re0, tx0, busy0;
    logic [7:0] rdata0;
    logic       rst1_n, en1, empty1, re1, tx1, busy1;
    logic [7:0] rdata1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] fifo0[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int re0_log[$];
    int falls0[$];
    int busy0_cnt = 0;
    int re1_cnt = 0;
    int busy1_cnt = 0;
    int frames0 = 0;
    int frames1 = 0;

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(4),
        .STOP_BITS(1)
    ) dut0 (
        .CLK_I(clk),
        .RST_NI(rst0_n),
        .EN_I(en0),
        .EMPTY_I(empty0),
        .R_DATA_I(rdata0),
        .RE_O(re0),
        .TX_O(tx0),
        .BUSY_O(busy0)
    );

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(3),
        .STOP_BITS(2)
    ) dut1 (
        .CLK_I(clk),
        .RST_NI(rst1_n),
        .EN_I(en1),
        .EMPTY_I(empty1),
        .R_DATA_I(rdata1),
        .RE_O(re1),
        .TX_O(tx1),
        .BUSY_O(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx0 : tx1;
    endfunction

    function automatic logic rst_of(input int w);
        return (w == 0) ? rst0_n : rst1_n;
    endfunction

    // FIFO model: the pop lands after the edge that latched the data
    initial begin : fifo_model
        logic pend;
        logic [7:0] junk;
        empty0 = 1'b1;
        rdata0 = 8'h00;
        forever begin
            @(negedge clk);
            pend = re0;
            @(posedge clk);
            #2;
            if (pend && fifo0.size() > 0) junk = fifo0.pop_front();
            empty0 = (fifo0.size() == 0);
            rdata0 = empty0 ? 8'h00 : fifo0[0];
        end
    end

    initial begin : recorder
        forever begin
            @(negedge clk);
            if (re0) re0_log.push_back(cyc);
            if (busy0) busy0_cnt++;
            if (re1) re1_cnt++;
            if (busy1) busy1_cnt++;
        end
    end

    // Reference serial model: sample every cycle of a frame
    task automatic mon(input int w, input int n, input int s);
        logic prev;
        logic v;
        logic ok;
        logic abort;
        logic has;
        logic [7:0] b;
        logic [7:0] e;
        int total;
        int k;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_of(w) && prev && !tx_of(w)) begin
                if (w == 0) falls0.push_back(cyc);
                total = (9 + s) * n;
                ok = 1'b1;
                abort = 1'b0;
                b = 8'h00;
                for (int i = 0; i < total; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_of(w)) begin
                        abort = 1'b1;
                        break;
                    end
                    v = tx_of(w);
                    if (i < n) begin
                        if (v !== 1'b0) ok = 1'b0;
                    end else if (i < 9 * n) begin
                        k = (i - n) / n;
                        if ((i - n) % n == 0) b[k] = v;
                        else if (v !== b[k]) ok = 1'b0;
                    end else if (v !== 1'b1) begin
                        ok = 1'b0;
                    end
                end
                if (!abort) begin
                    e = 8'h00;
                    if (w == 0) begin
                        has = (exp0.size() > 0);
                        if (has) e = exp0.pop_front();
                    end else begin
                        has = (exp1.size() > 0);
                        if (has) e = exp1.pop_front();
                    end
                    check("frame_expected", 32'(has), 32'd1);
                    check("frame_shape", 32'(ok), 32'd1);
                    check("frame_byte", 32'(b), 32'(e));
                    if (w == 0) frames0++;
                    else frames1++;
                end
                prev = 1'b1;
            end else begin
                prev = tx_of(w);
            end
        end
    endtask

    initial mon(0, 4, 1);
    initial mon(1, 3, 2);

    task automatic wait_frames(input int w, input int k,
                               input int budget,
                               input string name);
        int t;
        t = 0;
        while (((w == 0) ? frames0 : frames1) < k && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(((w == 0) ? frames0 : frames1) >= k), 32'd1);
    endtask

    task automatic clear_logs();
        re0_log.delete();
        falls0.delete();
        busy0_cnt = 0;
        re1_cnt = 0;
        busy1_cnt = 0;
    endtask

    initial begin : stim
        int bad;
        int t;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        en0 = 1'b1;
        en1 = 1'b1;
        empty1 = 1'b1;
        rdata1 = 8'h00;

        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_re", 32'(re0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        tick();
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || re0 !== 1'b0 || busy0 !== 1'b0) bad++;
            if (tx1 !== 1'b1 || re1 !== 1'b0 || busy1 !== 1'b0) bad++;
        end
        check("idle_50", 32'(bad), 32'd0);

        // single byte
        tick();
        clear_logs();
        fifo0.push_back(8'hA5);
        exp0.push_back(8'hA5);
        wait_frames(0, 1, 100, "a5_done");
        repeat (20) @(negedge clk);
        check("a5_re_count", 32'(re0_log.size()), 32'd1);
        check("a5_busy", 32'(busy0_cnt), 32'd40);
        if (re0_log.size() > 0 && falls0.size() > 0)
            check("a5_fall_lat", 32'(falls0[0] - re0_log[0]), 32'd1);
        else
            check("a5_fall_seen", 32'd0, 32'd1);

        // back-to-back
        tick();
        clear_logs();
        fifo0.push_back(8'h00);
        fifo0.push_back(8'hFF);
        exp0.push_back(8'h00);
        exp0.push_back(8'hFF);
        wait_frames(0, 3, 200, "b2b_done");
        repeat (20) @(negedge clk);
        check("b2b_re_count", 32'(re0_log.size()), 32'd2);
        check("b2b_busy", 32'(busy0_cnt), 32'd80);
        if (re0_log.size() == 2 && falls0.size() == 2) begin
            check("b2b_re_gap", 32'(re0_log[1] - re0_log[0]), 32'd41);
            check("b2b_fall_gap", 32'(falls0[1] - falls0[0]), 32'd41);
        end else begin
            check("b2b_logs", 32'(falls0.size()), 32'd2);
        end

        // enable gating, then drop enable mid-frame
        tick();
        en0 = 1'b0;
        clear_logs();
        fifo0.push_back(8'h3C);
        fifo0.push_back(8'h5A);
        exp0.push_back(8'h3C);
        repeat (100) @(negedge clk);
        check("en_gate_re", 32'(re0_log.size()), 32'd0);
        tick();
        en0 = 1'b1;
        @(negedge clk);
        check("en_rise_re", 32'(re0), 32'd1);
        @(negedge clk);
        check("en_start_bit", 32'(tx0), 32'd0);
        repeat (10) tick();
        en0 = 1'b0;
        wait_frames(0, 4, 100, "3c_done");
        repeat (60) @(negedge clk);
        check("en_drop_re", 32'(re0_log.size()), 32'd1);
        check("en_drop_fifo", 32'(fifo0.size()), 32'd1);

        // reset at the bit-3 midpoint of 0x5A
        tick();
        clear_logs();
        en0 = 1'b1;
        repeat (18) tick();
        rst0_n = 1'b0;
        fifo0.push_back(8'h11);
        exp0.push_back(8'h11);
        @(negedge clk);
        @(negedge clk);
        check("abort_tx", 32'(tx0), 32'd1);
        check("abort_busy", 32'(busy0), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_pop", 32'(re0_log.size()), 32'd1);
        tick();
        rst0_n = 1'b1;
        wait_frames(0, 5, 100, "11_done");

        // two stop bits on dut1
        tick();
        clear_logs();
        rdata1 = 8'h81;
        empty1 = 1'b0;
        exp1.push_back(8'h81);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!re1 && t < 50);
        check("s2_re_seen", 32'(re1), 32'd1);
        tick();
        empty1 = 1'b1;
        rdata1 = 8'h00;
        wait_frames(1, 1, 100, "s2_done");
        repeat (20) @(negedge clk);
        check("s2_busy", 32'(busy1_cnt), 32'd33);
        check("s2_re_count", 32'(re1_cnt), 32'd1);
        check("s2_leftover", 32'(exp0.size() + exp1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
UART transmit engine that drains the debug-interface byte FIFO from its read side. It pops one byte whenever the FIFO reports non-empty and transmission is enabled. Each byte is serialised as an 8N1 (or 8N2) frame on TX_O at a fixed clocks-per-bit rate. It sits between the TX FIFO and the UART pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (e.g. 50 MHz / 115200); legal range >= 2
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
CLK_I  input  1  system clock, all logic on rising edge
RST_NI  input  1  synchronous active-low reset
EN_I  input  1  transmit enable; when low no new byte is popped
EMPTY_I  input  1  FIFO empty flag
R_DATA_I  input  8  FIFO read data, combinationally valid while EMPTY_I=0
RE_O  output  1  FIFO read-enable (pop) pulse, one cycle per byte
TX_O  output  1  serial line, idle high
BUSY_O  output  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset (RST_NI=0 at a rising edge):
  - state=IDLE; TX_O=1, RE_O=0, BUSY_O=0.
  - Bit counter, baud counter and shift register are cleared.
  - Reset mid-frame aborts the frame. TX_O returns high on the next cycle, and no further pop occurs.
- RE_O is combinational from state and inputs: RE_O = (state==IDLE) & EN_I & ~EMPTY_I & RST_NI.
  - RE_O never asserts in any other state.
  - At most one pop per frame.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - TX_O=1.
  - If EN_I & ~EMPTY_I: latch R_DATA_I into the 8-bit shift register in the same cycle RE_O is high, clear the baud counter, and go to START.
  - Otherwise stay in IDLE.
- START:
  - TX_O=0 for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, go to DATA with bit index 0.
- DATA:
  - TX_O = shift[0] (LSB first). Each bit is held CLKS_PER_BIT cycles.
  - At the end of each bit, shift right and increment the bit index (3 bits).
  - After bit index 7 completes, go to STOP.
- STOP:
  - TX_O=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It is reset to 0 on every bit boundary and never wraps otherwise.
- Frame timing:
  - First TX_O falling edge occurs one cycle after the RE_O cycle.
  - A frame lasts (9+STOP_BITS)*CLKS_PER_BIT cycles.
  - Back-to-back bytes have exactly one IDLE cycle (TX_O=1) between the end of stop and the next start bit.
- TX_O is registered (driven from a flop), glitch-free.
- EN_I deasserted mid-frame does not abort the frame. It only prevents the next pop from IDLE.
- EMPTY_I / R_DATA_I changes after the pop cycle are ignored until the next IDLE.
- If EMPTY_I=1 in IDLE, RE_O stays 0 regardless of EN_I. The block never pops an empty FIFO.
- BUSY_O = (state != IDLE), registered with the state.

Test Plan:
- Reset/idle: hold RST_NI=0 for 3 cycles, then release with EMPTY_I=1, EN_I=1 -> TX_O=1, RE_O=0, BUSY_O=0 for 50 cycles.
- Single byte: CLKS_PER_BIT=4, STOP_BITS=1, FIFO holds 0xA5.
  - Exactly one RE_O pulse.
  - TX_O = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - BUSY_O high for 40 cycles.
  - No further RE_O once EMPTY_I=1.
- Back-to-back: FIFO holds 0x00, 0xFF with CLKS_PER_BIT=4.
  - Two RE_O pulses exactly 41 cycles apart.
  - Frame 1 shows a 36-cycle low period (start plus data); frame 2 shows 4-cycle low then 32 cycles high.
  - Exactly one idle-high cycle separates the frames.
- Enable gating: EMPTY_I=0, EN_I=0 for 100 cycles -> RE_O never asserts. Raising EN_I -> RE_O pulses in that same cycle and the start bit follows on the next cycle.
- Mid-frame events: drop EN_I during DATA of 0x3C -> frame completes correctly and no new pop occurs. Assert RST_NI=0 at the bit-3 midpoint -> TX_O=1, BUSY_O=0 on the next cycle, and no RE_O until released.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=3, byte 0x81 -> stop-high duration 6 cycles and total frame 33 cycles, checked against the reference serial model.
